// File: rtl/oqpsk_pkg.sv
// Shared types and helpers for the parametrised OQPSK raised-cosine modulator.
// Sign states for the I/Q symbols and the pulse-shape coefficient generator used to fill the ROM.
package oqpsk_pkg;

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        POS      = 2'd1,
        NEG      = 2'd2
    } sign_t;

    // Rounded raised-cosine tap; the small bias keeps exact .5 values from rounding down on float error.
    function automatic int rcos_coef(input int n, input int sps, input int coef_w);
        real amp;
        real ph;
        amp = real'((1 << coef_w) - 1);
        ph  = 2.0 * 3.14159265358979323846 * real'(n) / real'(sps);
        return $rtoi(amp * 0.5 * (1.0 - $cos(ph)) + 0.5 + 1.0e-6);
    endfunction

endpackage

// File: rtl/oqpsk_rcos_mod_param_rom.sv
// SPS-entry raised-cosine coefficient ROM with two independently addressed registered read ports.
module rcos_coef_rom
    import oqpsk_pkg::*;
#(
    parameter int SPS    = 64,
    parameter int COEF_W = 12,
    localparam int ADDR_W = $clog2(SPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] addr_q,
    output logic [COEF_W-1:0] coef_i,
    output logic [COEF_W-1:0] coef_q
);

    logic [COEF_W-1:0] rom [SPS];

    for (genvar n = 0; n < SPS; n++) begin : g_rom
        assign rom[n] = COEF_W'(rcos_coef(n, SPS, COEF_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_i <= '0;
            coef_q <= '0;
        end else begin
            coef_i <= rom[addr_i];
            coef_q <= rom[addr_q];
        end
    end

endmodule

// File: rtl/oqpsk_rcos_mod_param.sv
// OQPSK/QPSK modulator: serial bit FIFO, symbol pairing, sample counter and a
// two-stage pipe (coefficient read, then sign application) from request to output.
module oqpsk_rcos_mod_param
    import oqpsk_pkg::*;
#(
    parameter int SPS        = 64,
    parameter int COEF_W     = 12,
    parameter int FIFO_DEPTH = 8,
    localparam int ADDR_W    = $clog2(SPS),
    localparam int OUT_W     = COEF_W + 1
) (
    input  logic                    ACK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    OFFSET_EN,
    input  logic                    Bit_In,
    input  logic                    BIT_VALID,
    output logic                    BIT_READY,
    input  logic                    REQ_SAMPLE,
    output logic                    SAMPLE_VALID,
    output logic signed [OUT_W-1:0] I,
    output logic signed [OUT_W-1:0] Q,
    output logic [ADDR_W-1:0]       addI,
    output logic [ADDR_W-1:0]       addQ,
    output logic                    UNDERRUN
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(SPS / 2);

    // Bit input handshake: a bit transfers on any cycle where BIT_VALID and BIT_READY are both high;
    // BIT_READY depends only on the registered fill level, so a pop in the same cycle never frees a slot early.
    logic [FIFO_DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic                  bit0;
    logic                  bit1;

    assign BIT_READY = (count < CNT_W'(FIFO_DEPTH));
    assign push      = BIT_VALID & BIT_READY;
    assign bit0      = fifo_mem[rd_ptr];
    assign bit1      = fifo_mem[rd_ptr + PTR_W'(1)];

    logic              req_acc;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] q_idx;
    logic              i_bnd;
    logic              q_bnd;
    logic              have_sym;

    assign req_acc  = REQ_SAMPLE & EN;
    assign q_idx    = OFFSET_EN ? k + HALF : k;
    assign i_bnd    = req_acc && (k == '0);
    assign q_bnd    = req_acc && (q_idx == '0);
    assign have_sym = (count >= CNT_W'(2));
    assign pop      = i_bnd & have_sym;

    sign_t i_state, i_state_n;
    sign_t q_pend, q_pend_n;
    sign_t q_state, q_state_n;
    logic  underrun_n;

    always_comb begin
        i_state_n  = i_state;
        q_pend_n   = q_pend;
        q_state_n  = q_state;
        underrun_n = 1'b0;
        if (i_bnd) begin
            if (have_sym) begin
                i_state_n = bit0 ? POS : NEG;
                q_pend_n  = bit1 ? POS : NEG;
            end else begin
                i_state_n  = INACTIVE;
                q_pend_n   = INACTIVE;
                underrun_n = 1'b1;
            end
        end
        // In QPSK this picks up the symbol popped on the same request; in OQPSK q_pend_n equals q_pend here.
        if (q_bnd) begin
            q_state_n = q_pend_n;
        end
    end

    always_ff @(posedge ACK) begin
        if (RST) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            k        <= '0;
            i_state  <= INACTIVE;
            q_pend   <= INACTIVE;
            q_state  <= INACTIVE;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= Bit_In;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(2);
            end
            count <= count + CNT_W'(push) - (pop ? CNT_W'(2) : CNT_W'(0));
            if (req_acc) begin
                k <= k + ADDR_W'(1);
            end
            i_state <= i_state_n;
            q_pend  <= q_pend_n;
            q_state <= q_state_n;
        end
    end

    logic [COEF_W-1:0] coef_i;
    logic [COEF_W-1:0] coef_q;

    rcos_coef_rom #(
        .SPS    (SPS),
        .COEF_W (COEF_W)
    ) u_rom (
        .clk    (ACK),
        .rst    (RST),
        .addr_i (k),
        .addr_q (q_idx),
        .coef_i (coef_i),
        .coef_q (coef_q)
    );

    logic              s1_valid;
    logic              s1_underrun;
    logic [ADDR_W-1:0] s1_addr_i;
    logic [ADDR_W-1:0] s1_addr_q;
    sign_t             s1_sign_i;
    sign_t             s1_sign_q;

    function automatic logic signed [OUT_W-1:0] shape(input sign_t s, input logic [COEF_W-1:0] c);
        logic signed [OUT_W-1:0] mag;
        mag = signed'({1'b0, c});
        case (s)
            POS:     return mag;
            NEG:     return -mag;
            default: return '0;
        endcase
    endfunction

    // Pipe stages are not gated by EN so requests already accepted always drain.
    always_ff @(posedge ACK) begin
        if (RST) begin
            s1_valid     <= 1'b0;
            s1_underrun  <= 1'b0;
            s1_addr_i    <= '0;
            s1_addr_q    <= '0;
            s1_sign_i    <= INACTIVE;
            s1_sign_q    <= INACTIVE;
            SAMPLE_VALID <= 1'b0;
            UNDERRUN     <= 1'b0;
            I            <= '0;
            Q            <= '0;
            addI         <= '0;
            addQ         <= '0;
        end else begin
            s1_valid     <= req_acc;
            s1_underrun  <= underrun_n;
            s1_addr_i    <= k;
            s1_addr_q    <= q_idx;
            s1_sign_i    <= i_state_n;
            s1_sign_q    <= q_state_n;
            SAMPLE_VALID <= s1_valid;
            UNDERRUN     <= s1_valid & s1_underrun;
            if (s1_valid) begin
                I    <= shape(s1_sign_i, coef_i);
                Q    <= shape(s1_sign_q, coef_q);
                addI <= s1_addr_i;
                addQ <= s1_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_oqpsk_rcos_mod_param.sv
// Bench for oqpsk_rcos_mod_param (SPS=8, COEF_W=12): directed scenarios then random traffic,
// all samples scored against a symbol-level model of the modulator.
module tb_oqpsk_rcos_mod_param;

    localparam int SPS    = 8;
    localparam int COEF_W = 12;
    localparam int FD     = 8;
    localparam int ADDR_W = $clog2(SPS);
    localparam int OUT_W  = COEF_W + 1;

    logic                    ACK;
    logic                    RST;
    logic                    EN;
    logic                    offset_en;
    logic                    Bit_In;
    logic                    BIT_VALID;
    logic                    BIT_READY;
    logic                    REQ_SAMPLE;
    logic                    SAMPLE_VALID;
    logic signed [OUT_W-1:0] I;
    logic signed [OUT_W-1:0] Q;
    logic [ADDR_W-1:0]       addI;
    logic [ADDR_W-1:0]       addQ;
    logic                    UNDERRUN;

    oqpsk_rcos_mod_param #(
        .SPS        (SPS),
        .COEF_W     (COEF_W),
        .FIFO_DEPTH (FD)
    ) dut (
        .ACK          (ACK),
        .RST          (RST),
        .EN           (EN),
        .OFFSET_EN    (offset_en),
        .Bit_In       (Bit_In),
        .BIT_VALID    (BIT_VALID),
        .BIT_READY    (BIT_READY),
        .REQ_SAMPLE   (REQ_SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .I            (I),
        .Q            (Q),
        .addI         (addI),
        .addQ         (addQ),
        .UNDERRUN     (UNDERRUN)
    );

    // clock/reset block
    initial ACK = 1'b0;
    always #5 ACK = ~ACK;

    int cyc = 0;
    always @(posedge ACK) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // reference model state: signs are +1 / -1 / 0 (inactive)
    int coef_tbl [SPS] = '{0, 600, 2048, 3495, 4095, 3495, 2048, 600};
    bit m_bits[$];
    int m_k  = 0;
    int m_is = 0;
    int m_qp = 0;
    int m_qs = 0;

    typedef struct {
        int i;
        int q;
        int ai;
        int aq;
        int und;
        int due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    // driver tasks: called just after a rising edge, drive one cycle, return after the next edge
    task automatic drive(input logic bv, input logic b, input logic req, input logic en);
        exp_t e;
        int   qi;
        int   und;
        logic rdy;
        BIT_VALID  = bv;
        Bit_In     = b;
        REQ_SAMPLE = req;
        EN         = en;
        rdy = (m_bits.size() < FD);
        check("bit_ready", int'(BIT_READY), int'(rdy));
        if (req && en) begin
            und = 0;
            if (m_k == 0) begin
                if (m_bits.size() >= 2) begin
                    m_is = m_bits.pop_front() ? 1 : -1;
                    m_qp = m_bits.pop_front() ? 1 : -1;
                end else begin
                    m_is = 0;
                    m_qp = 0;
                    und  = 1;
                end
            end
            qi = offset_en ? (m_k + SPS / 2) % SPS : m_k;
            if (qi == 0) m_qs = m_qp;
            e.i   = m_is * coef_tbl[m_k];
            e.q   = m_qs * coef_tbl[qi];
            e.ai  = m_k;
            e.aq  = qi;
            e.und = und;
            e.due = cyc + 2;
            exp_q.push_back(e);
            m_k = (m_k + 1) % SPS;
        end
        if (bv && rdy) m_bits.push_back(b);
        @(posedge ACK);
        #1;
    endtask

    task automatic apply_reset();
        exp_t keep[$];
        RST        = 1'b1;
        BIT_VALID  = 1'b0;
        REQ_SAMPLE = 1'b0;
        EN         = 1'b0;
        foreach (exp_q[j]) if (exp_q[j].due <= cyc) keep.push_back(exp_q[j]);
        exp_q = keep;
        repeat (2) begin
            @(posedge ACK);
            #1;
        end
        m_bits.delete();
        m_k  = 0;
        m_is = 0;
        m_qp = 0;
        m_qs = 0;
        check("rst_I", int'(I), 0);
        check("rst_Q", int'(Q), 0);
        check("rst_addI", int'(addI), 0);
        check("rst_addQ", int'(addQ), 0);
        check("rst_valid", int'(SAMPLE_VALID), 0);
        check("rst_ready", int'(BIT_READY), 1);
        check("rst_underrun", int'(UNDERRUN), 0);
        RST = 1'b0;
    endtask

    task automatic push_bit(input logic b);
        drive(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic requests(input int n);
        for (int r = 0; r < n; r++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int r = 0; r < n; r++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard: outputs sampled on the falling edge
    always @(negedge ACK) begin
        if (mon_en) begin
            if (SAMPLE_VALID) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", int'(SAMPLE_VALID), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc, mon_e.due);
                    check("I", int'(I), mon_e.i);
                    check("Q", int'(Q), mon_e.q);
                    check("addI", int'(addI), mon_e.ai);
                    check("addQ", int'(addQ), mon_e.aq);
                    check("underrun", int'(UNDERRUN), mon_e.und);
                end
            end else begin
                check("underrun_idle", int'(UNDERRUN), 0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("missing_valid", int'(SAMPLE_VALID), 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        RST        = 1'b1;
        EN         = 1'b0;
        offset_en  = 1'b1;
        Bit_In     = 1'b0;
        BIT_VALID  = 1'b0;
        REQ_SAMPLE = 1'b0;

        // reset state
        apply_reset();
        mon_en = 1'b1;

        // OQPSK symbol 1,0
        push_bit(1'b1);
        push_bit(1'b0);
        requests(8);
        idle(3);

        // QPSK symbol 0,1
        offset_en = 1'b0;
        idle(1);
        push_bit(1'b0);
        push_bit(1'b1);
        requests(8);
        idle(3);

        // underrun with a single buffered bit, then that bit pairs with the next one
        push_bit(1'b1);
        requests(8);
        idle(3);
        push_bit(1'b0);
        requests(8);
        idle(3);

        // FIFO fill to capacity, ninth bit refused, space returns after a symbol start
        for (int n = 0; n < 9; n++) push_bit(1'($urandom_range(0, 1)));
        requests(8);
        idle(3);

        // pause at k=3 with requests held, resume, then reset at k=5
        offset_en = 1'b1;
        idle(1);
        requests(3);
        for (int n = 0; n < 5; n++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        requests(2);
        apply_reset();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) begin
                idle(1);
                offset_en = 1'($urandom_range(0, 1));
                idle(1);
            end else begin
                drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
            end
        end

        idle(4);
        check("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
